// File: rtl/ser_tx.sv
// Parallel-to-serial transmitter: loads one WIDTH-bit word every WIDTH enabled
// cycles and shifts it out one bit per cycle, substituting IDLE_WORD on a miss.
module ser_tx #(
  parameter int unsigned        WIDTH     = 10,
  parameter bit                 LSB_FIRST = 1'b0,
  parameter logic [WIDTH-1:0]   IDLE_WORD = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out,
  output logic             frame,
  output logic             underflow
);

  // Handshake: a transfer happens on a rising edge where in_valid and in_ready
  // are both high. in_ready depends only on the bit counter and en, never on
  // in_valid, so the source may hold in_valid high for any number of cycles.

  localparam int unsigned    CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] shift;
  logic [WIDTH-1:0] shift_next;
  logic             load_slot;

  assign load_slot = en && (cnt == LAST);
  assign in_ready  = load_slot;

  // Shift direction is chosen so the bit on out is always the next one to send.
  always_comb begin
    shift_next = shift;
    if (LSB_FIRST) begin
      shift_next = {1'b0, shift[WIDTH-1:1]};
    end else begin
      shift_next = {shift[WIDTH-2:0], 1'b0};
    end
  end

  // Reset parks the counter on the last bit so the first enabled cycle loads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= LAST;
      shift     <= '0;
      frame     <= 1'b0;
      underflow <= 1'b0;
    end else if (en) begin
      cnt       <= (cnt == LAST) ? '0 : cnt + CW'(1);
      frame     <= load_slot;
      underflow <= load_slot && !in_valid;
      if (load_slot) begin
        shift <= in_valid ? in_data : IDLE_WORD;
      end else begin
        shift <= shift_next;
      end
    end
  end

  assign out = LSB_FIRST ? shift[0] : shift[WIDTH-1];

endmodule

// File: tb/tb_ser_tx.sv
// Bench for ser_tx: an MSB-first and an LSB-first instance share the same
// stimulus and are checked against a word/bit-position reference model.
module tb_ser_tx;

  localparam int W = 10;
  localparam logic [W-1:0] IDLE_M = 10'h155;
  localparam logic [W-1:0] IDLE_L = 10'h2A3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0;
  logic [W-1:0] in_data = '0;
  logic in_valid = 1'b0;
  logic rdy_m, out_m, frame_m, uf_m;
  logic rdy_l, out_l, frame_l, uf_l;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ser_tx #(.WIDTH(W), .LSB_FIRST(1'b0), .IDLE_WORD(IDLE_M)) dut_m (
    .clk(clk), .rst(rst), .en(en), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy_m), .out(out_m), .frame(frame_m), .underflow(uf_m)
  );

  ser_tx #(.WIDTH(W), .LSB_FIRST(1'b1), .IDLE_WORD(IDLE_L)) dut_l (
    .clk(clk), .rst(rst), .en(en), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy_l), .out(out_l), .frame(frame_l), .underflow(uf_l)
  );

  // Reference model: count enabled edges since reset; every W-th edge starting
  // with the first is a load. The word on the line and the position within it
  // give the expected serial bit directly.
  int           m_edges;
  bit           m_loaded;
  bit           m_idle;
  logic [W-1:0] m_word;
  int           m_pos;
  bit           m_frame;

  logic [19:0] cap_m, cap_l;
  int          ready_cnt, uf_cnt;
  bit          last_xfer;

  task automatic model_reset();
    m_edges = 0; m_loaded = 0; m_idle = 0; m_word = '0; m_pos = 0; m_frame = 0;
  endtask

  function automatic bit exp_ready();
    return en && (m_edges % W == 0);
  endfunction

  function automatic logic exp_bit(bit lsb_first);
    logic [W-1:0] w;
    if (!m_loaded) return 1'b0;
    w = m_idle ? (lsb_first ? IDLE_L : IDLE_M) : m_word;
    return lsb_first ? logic'((w >> m_pos) & 1) : logic'((w >> (W - 1 - m_pos)) & 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs();
    chk("out_m", 32'(out_m), 32'(exp_bit(1'b0)));
    chk("out_l", 32'(out_l), 32'(exp_bit(1'b1)));
    chk("frame_m", 32'(frame_m), 32'(m_frame));
    chk("frame_l", 32'(frame_l), 32'(m_frame));
    chk("underflow_m", 32'(uf_m), 32'(m_frame && m_idle));
    chk("underflow_l", 32'(uf_l), 32'(m_frame && m_idle));
  endtask

  // One clock cycle: drive at posedge+1, check in_ready, take the edge, check.
  task automatic step(input logic e, input logic v, input logic [W-1:0] d);
    bit slot;
    en = e; in_valid = v; in_data = d;
    #1;
    slot = exp_ready();
    chk("in_ready_m", 32'(rdy_m), 32'(slot));
    chk("in_ready_l", 32'(rdy_l), 32'(slot));
    if (rdy_m) ready_cnt++;
    last_xfer = slot && v;
    @(posedge clk);
    if (e) begin
      if (slot) begin
        m_loaded = 1; m_idle = !v; m_word = d; m_pos = 0; m_frame = 1;
      end else begin
        m_pos++; m_frame = 0;
      end
      m_edges++;
    end
    #1;
    check_outputs();
    if (e) begin
      cap_m = {cap_m[18:0], out_m};
      cap_l = {cap_l[18:0], out_l};
      if (uf_m) uf_cnt++;
    end
  endtask

  initial begin
    bit           have;
    logic [W-1:0] pend;
    logic         e_r;
    model_reset();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    en = 1'b1;
    #1;
    chk("ready_in_reset", 32'(rdy_m), 32'd1);
    en = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;

    // Single word 2D5 then back-to-back 3FF, 001
    cap_m = '0; cap_l = '0;
    step(1, 1, 10'h2D5);
    chk("first_frame", 32'(frame_m), 32'd1);
    for (int i = 1; i < 10; i++) step(1, 1, 10'h3FF);
    chk("word_2d5_bits", 32'(cap_m[9:0]), 32'h2D5);
    ready_cnt = 0;
    for (int i = 0; i < 10; i++) step(1, 1, (i == 0) ? 10'h3FF : 10'h001);
    for (int i = 0; i < 10; i++) step(1, 1, 10'h001);
    chk("stream_bits", 32'(cap_m), 32'hFFC01);
    chk("stream_ready_count", 32'(ready_cnt), 32'd2);

    // Underflow: idle word on a missed slot
    uf_cnt = 0;
    for (int i = 0; i < 10; i++) step(1, 0, 10'h3C3);
    chk("idle_bits", 32'(cap_m[9:0]), 32'h155);
    chk("underflow_pulses", 32'(uf_cnt), 32'd1);

    // LSB-first instance sends bit 0 first
    for (int i = 0; i < 10; i++) step(1, (i == 0), 10'h001);
    chk("lsb_first_bits", 32'(cap_l[9:0]), 32'h200);

    // Clock enable low for 3 cycles mid-word
    for (int i = 0; i < 4; i++) step(1, (i == 0), 10'h2D5);
    for (int i = 0; i < 3; i++) step(0, 1, 10'h2D5);
    for (int i = 0; i < 6; i++) step(1, 0, 10'h000);
    chk("freeze_bits", 32'(cap_m[9:0]), 32'h2D5);

    // Asynchronous reset at bit 4 of a word
    for (int i = 0; i < 4; i++) step(1, 1, 10'h3FF);
    chk("pre_reset_bit", 32'(out_m), 32'd1);
    rst = 1'b1;
    #1;
    model_reset();
    check_outputs();
    @(posedge clk); #1;
    rst = 1'b0;
    step(1, 1, 10'h0F0);
    chk("load_after_reset", 32'(frame_m), 32'd1);

    // Randomized traffic; a presented word is held until it transfers
    have = 0; pend = '0;
    for (int i = 0; i < 400; i++) begin
      if (!have) begin
        have = ($urandom_range(0, 3) != 0);
        pend = W'($urandom_range(0, (1 << W) - 1));
      end
      e_r = ($urandom_range(0, 9) < 8);
      step(e_r, have, pend);
      if (last_xfer) have = 0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog so the bench always ends
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ser_tx.md
SER_TX -- requirements
Module: ser_tx

Interface
REQ-001 Parameter WIDTH, default 10: parallel word width in bits; legal range 2..32.
REQ-002 Parameter LSB_FIRST, default 0: 0 sends bit WIDTH-1 first; 1 sends bit 0 first.
REQ-003 Parameter IDLE_WORD, default 0 (WIDTH bits): word sent when no data is available at a load slot.
REQ-004 clk  input  1  single clock; all state is updated on the rising edge.
REQ-005 rst  input  1  reset; asynchronous, active-high.
REQ-006 en  input  1  clock enable; when low, all state SHALL hold and in_ready SHALL be low.
REQ-007 in_data  input  WIDTH  parallel word to serialize.
REQ-008 in_valid  input  1  in_data is valid.
REQ-009 in_ready  output  1  combinational; high in a load slot while en=1.
REQ-010 out  output  1  serial bit, driven directly from the shift register.
REQ-011 frame  output  1  registered; high while the first bit of a word is on out.
REQ-012 underflow  output  1  registered; one-cycle pulse when IDLE_WORD is loaded due to a missing word.

Function
REQ-013 Bit counter cnt SHALL count 0..WIDTH-1 and wrap to 0, advancing once per cycle with en=1.
REQ-014 A load slot is a cycle with cnt==WIDTH-1 and en=1; in_ready SHALL equal that condition and SHALL NOT depend on in_valid.
REQ-015 A transfer occurs on a rising edge with in_valid=1 and in_ready=1; the shift register SHALL load in_data on that edge.
REQ-016 In a load slot with in_valid=0, the shift register SHALL load IDLE_WORD, and underflow SHALL be 1 for the following cycle.
REQ-017 In a non-load cycle with en=1, the shift register SHALL shift by one: toward MSB (LSB_FIRST=0) or toward LSB (LSB_FIRST=1), filling with 0.
REQ-018 out SHALL be shift[WIDTH-1] when LSB_FIRST=0 and shift[0] when LSB_FIRST=1.
REQ-019 Latency: the first bit of a word accepted at edge k SHALL appear on out after edge k; its remaining bits SHALL follow on consecutive enabled cycles.
REQ-020 Streaming SHALL be gapless: with in_valid held high, consecutive words SHALL appear back-to-back, one word every WIDTH enabled cycles.
REQ-021 frame SHALL be 1 for exactly the cycle following each load edge (word or IDLE_WORD), else 0.
REQ-022 With en=0, cnt, shift, frame and underflow SHALL hold their values, out SHALL hold, and no transfer SHALL occur.
REQ-023 The upstream source SHALL hold in_data/in_valid stable until the transfer; words presented outside a load slot SHALL NOT be consumed.

Reset
REQ-024 While rst=1: cnt=WIDTH-1, shift=0, frame=0, underflow=0; hence out=0.
REQ-025 The first enabled cycle after rst deasserts SHALL be a load slot.
REQ-026 Assertion of rst mid-word SHALL discard the word in flight immediately (asynchronously); no partial-word resume occurs.

Verification (WIDTH=10 unless noted)
REQ-027 Reset, then in_valid=1, in_data=10'h2D5, en=1 -> in_ready=1 in the first cycle; out after that edge = 1,0,1,1,0,1,0,1,0,1; frame=1 only on the first bit.
REQ-028 Words 10'h3FF then 10'h001 presented back-to-back -> 20 consecutive out bits: ten 1s, nine 0s, then 1; in_ready high once per 10 cycles.
REQ-029 in_valid=0 at a load slot, IDLE_WORD=10'h155 -> out = 0101010101; underflow pulses exactly one cycle, aligned with frame.
REQ-030 LSB_FIRST=1, in_data=10'h001 -> out = 1 then nine 0s.
REQ-031 en toggled low for 3 cycles mid-word -> out and frame freeze; bit sequence resumes unchanged; in_ready stays low while en=0.
REQ-032 rst pulsed at bit 4 of a word -> out=0 immediately; next load slot occurs in the first enabled cycle after release.
